thor2022_regsrc_ckpt_map: RTL and testbench

//  Parametrised register-source map for the Thor2022 out-of-order core.
//  - Per architectural register: pending flag + reorder-buffer (REB) id of its youngest in-flight producer.
//  - Written by NDEC decode slots; cleared by NCMT commit ports.
//  - Holds NCKPT branch checkpoints, so a branch miss restores the map in one cycle instead of rebuilding it from the REB.
//  - Sits between decode/rename and operand fetch.

---
 rtl/thor2022_regsrc_ckpt_map.sv | 188 ++++++++++++++++++
 tb/tb_thor2022_regsrc_ckpt_map.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/thor2022_regsrc_ckpt_map.sv
// Register-source map with branch checkpoints for the Thor2022 out-of-order core.
// Tracks each architectural register's youngest in-flight producer. A mispredict restores the map from a checkpoint in one cycle.
module thor2022_regsrc_ckpt_map #(
    parameter int NREGS       = 64,
    parameter int REB_ENTRIES = 8,
    parameter int IDW         = $clog2(REB_ENTRIES),
    parameter int RW          = $clog2(NREGS),
    parameter int NDEC        = 2,
    parameter int NCMT        = 2,
    parameter int NCKPT       = 4,
    parameter int CW          = $clog2(NCKPT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NDEC-1:0]       dec_v,
    input  logic [NDEC-1:0]       dec_rfwr,
    input  logic [NDEC*RW-1:0]    dec_rt,
    input  logic [NDEC*IDW-1:0]   dec_id,
    input  logic [NDEC-1:0]       dec_br,
    output logic                  ckpt_ok,
    output logic [CW-1:0]         ckpt_alloc_id,
    input  logic [NCMT-1:0]       cmt_v,
    input  logic [NCMT*RW-1:0]    cmt_rt,
    input  logic [NCMT*IDW-1:0]   cmt_id,
    input  logic                  rel_v,
    input  logic [CW-1:0]         rel_ckpt,
    input  logic                  miss_v,
    input  logic [CW-1:0]         miss_ckpt,
    output logic [NREGS-1:0]      reg_pending,
    output logic [NREGS*IDW-1:0]  reg_src
);

    logic [NREGS-1:0] pend_reg, pend_next, pend_cmt, st_pend, snap_pend;
    logic [IDW-1:0]   src_reg [NREGS];
    logic [IDW-1:0]   src_next [NREGS];
    logic [IDW-1:0]   st_src [NREGS];
    logic [IDW-1:0]   snap_src [NREGS];

    logic [NREGS-1:0] ck_pend_reg [NCKPT];
    logic [NREGS-1:0] ck_pend_cmt [NCKPT];
    logic [IDW-1:0]   ck_src_reg [NCKPT][NREGS];

    // age_reg[a][b] = 1 means slot a was allocated after (is younger than) slot b
    logic [NCKPT-1:0] age_reg [NCKPT];
    logic [NCKPT-1:0] age_next [NCKPT];
    logic [NCKPT-1:0] busy_reg, busy_next, free_mask;

    logic br_any, alloc_v, miss_eff;

    // Commit clears against the live map; a mismatched id means a younger producer owns the register
    always_comb begin
        pend_cmt = pend_reg;
        for (int k = 0; k < NCMT; k++) begin
            if (cmt_v[k] && pend_reg[cmt_rt[k*RW +: RW]]
                && src_reg[cmt_rt[k*RW +: RW]] == cmt_id[k*IDW +: IDW]) begin
                pend_cmt[cmt_rt[k*RW +: RW]] = 1'b0;
            end
        end
    end

    // Decode slots applied oldest first so a higher slot overrides; snapshot taken after the branch slot's own write
    always_comb begin
        st_pend   = pend_cmt;
        st_src    = src_reg;
        snap_pend = pend_cmt;
        snap_src  = src_reg;
        br_any    = 1'b0;
        for (int j = 0; j < NDEC; j++) begin
            if (dec_v[j] && dec_rfwr[j] && dec_rt[j*RW +: RW] != '0) begin
                st_pend[dec_rt[j*RW +: RW]] = 1'b1;
                st_src[dec_rt[j*RW +: RW]]  = dec_id[j*IDW +: IDW];
            end
            if (dec_v[j] && dec_br[j]) begin
                snap_pend = st_pend;
                snap_src  = st_src;
                br_any    = 1'b1;
            end
        end
    end

    // Checkpoints retire their own matching producers independently of the live map
    for (genvar gi = 0; gi < NCKPT; gi++) begin : gen_ck_cmt
        logic [NREGS-1:0] clr;
        always_comb begin
            clr = '0;
            for (int k = 0; k < NCMT; k++) begin
                if (cmt_v[k] && ck_pend_reg[gi][cmt_rt[k*RW +: RW]]
                    && ck_src_reg[gi][cmt_rt[k*RW +: RW]] == cmt_id[k*IDW +: IDW]) begin
                    clr[cmt_rt[k*RW +: RW]] = 1'b1;
                end
            end
        end
        assign ck_pend_cmt[gi] = ck_pend_reg[gi] & ~clr;
    end

    always_comb begin
        ckpt_ok       = ~&busy_reg;
        ckpt_alloc_id = '0;
        for (int c = NCKPT - 1; c >= 0; c--) begin
            if (!busy_reg[c]) ckpt_alloc_id = CW'(c);
        end
    end

    assign miss_eff = miss_v && busy_reg[miss_ckpt];
    assign alloc_v  = br_any && !miss_v && ckpt_ok;

    always_comb begin
        free_mask = '0;
        if (rel_v) free_mask[rel_ckpt] = 1'b1;
        if (miss_eff) begin
            free_mask[miss_ckpt] = 1'b1;
            for (int c = 0; c < NCKPT; c++) begin
                if (age_reg[c][miss_ckpt]) free_mask[c] = 1'b1;
            end
        end
    end

    always_comb begin
        busy_next = '0;
        for (int c = 0; c < NCKPT; c++) begin
            busy_next[c] = (busy_reg[c] && !free_mask[c]) || (alloc_v && ckpt_alloc_id == CW'(c));
            age_next[c]  = free_mask[c] ? '0 : (age_reg[c] & ~free_mask);
            if (alloc_v && ckpt_alloc_id == CW'(c)) age_next[c] = busy_reg & ~free_mask;
        end
    end

    always_comb begin
        pend_next = st_pend;
        src_next  = st_src;
        if (miss_v) begin
            pend_next = pend_cmt;
            src_next  = src_reg;
            if (miss_eff) begin
                pend_next = ck_pend_cmt[miss_ckpt];
                src_next  = ck_src_reg[miss_ckpt];
            end
        end
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg <= '0;
            busy_reg <= '0;
            for (int n = 0; n < NREGS; n++) src_reg[n] <= '0;
            for (int c = 0; c < NCKPT; c++) begin
                age_reg[c]     <= '0;
                ck_pend_reg[c] <= '0;
            end
        end else begin
            pend_reg <= pend_next;
            src_reg  <= src_next;
            busy_reg <= busy_next;
            age_reg  <= age_next;
            for (int c = 0; c < NCKPT; c++) begin
                if (alloc_v && ckpt_alloc_id == CW'(c)) begin
                    ck_pend_reg[c] <= {snap_pend[NREGS-1:1], 1'b0};
                end else begin
                    ck_pend_reg[c] <= ck_pend_cmt[c];
                end
            end
        end
    end

    // Source ids are only meaningful under a pending bit, so the checkpoint id array needs no reset
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCKPT; c++) begin
            if (!rst && alloc_v && ckpt_alloc_id == CW'(c)) ck_src_reg[c] <= snap_src;
        end
    end

    assign reg_pending = pend_reg;
    for (genvar gi = 0; gi < NREGS; gi++) begin : gen_src_out
        assign reg_src[gi*IDW +: IDW] = src_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(br_any && !miss_v && !ckpt_ok))
                else $error("dec_br with no free checkpoint");
            assert ($countones(dec_br & dec_v) <= 1)
                else $error("more than one dec_br in a cycle");
            assert (!(miss_v && !busy_reg[miss_ckpt]))
                else $error("miss_v on a free checkpoint");
        end
    end

endmodule

// File: tb/tb_thor2022_regsrc_ckpt_map.sv
// Directed table-driven bench for thor2022_regsrc_ckpt_map.
// Each vector is one clock of stimulus plus the expected state of one register and the checkpoint allocator.
module tb_thor2022_regsrc_ckpt_map;
    localparam int NREGS = 64;
    localparam int IDW   = 3;
    localparam int RW    = 6;
    localparam int NDEC  = 2;
    localparam int NCMT  = 2;
    localparam int NCKPT = 4;
    localparam int CW    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NDEC-1:0]      dec_v, dec_rfwr, dec_br;
    logic [NDEC*RW-1:0]   dec_rt;
    logic [NDEC*IDW-1:0]  dec_id;
    logic                 ckpt_ok;
    logic [CW-1:0]        ckpt_alloc_id;
    logic [NCMT-1:0]      cmt_v;
    logic [NCMT*RW-1:0]   cmt_rt;
    logic [NCMT*IDW-1:0]  cmt_id;
    logic                 rel_v, miss_v;
    logic [CW-1:0]        rel_ckpt, miss_ckpt;
    logic [NREGS-1:0]     reg_pending;
    logic [NREGS*IDW-1:0] reg_src;

    always #5 clk = ~clk;

    thor2022_regsrc_ckpt_map #(
        .NREGS(NREGS), .REB_ENTRIES(8), .IDW(IDW), .RW(RW),
        .NDEC(NDEC), .NCMT(NCMT), .NCKPT(NCKPT), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .dec_v(dec_v), .dec_rfwr(dec_rfwr), .dec_rt(dec_rt), .dec_id(dec_id), .dec_br(dec_br),
        .ckpt_ok(ckpt_ok), .ckpt_alloc_id(ckpt_alloc_id),
        .cmt_v(cmt_v), .cmt_rt(cmt_rt), .cmt_id(cmt_id),
        .rel_v(rel_v), .rel_ckpt(rel_ckpt), .miss_v(miss_v), .miss_ckpt(miss_ckpt),
        .reg_pending(reg_pending), .reg_src(reg_src)
    );

    // dv/dw/br/cv are 2-bit masks (bit0 = slot/port 0); chk is the register inspected after the edge
    typedef struct {
        int rst, dv, dw, rt0, id0, rt1, id1, br;
        int cv, crt0, cid0, crt1, cid1;
        int rel, relc, miss, missc;
        int chk, ep, es, eok, eaid;
    } vec_t;

    vec_t tv[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input vec_t v);
        tv.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        logic [31:0] t0, t1, t2, t3;
        rst      = v.rst[0];
        dec_v    = v.dv[1:0];
        dec_rfwr = v.dw[1:0];
        dec_br   = v.br[1:0];
        t0 = v.rt0; t1 = v.rt1; t2 = v.id0; t3 = v.id1;
        dec_rt   = {t1[RW-1:0], t0[RW-1:0]};
        dec_id   = {t3[IDW-1:0], t2[IDW-1:0]};
        cmt_v    = v.cv[1:0];
        t0 = v.crt0; t1 = v.crt1; t2 = v.cid0; t3 = v.cid1;
        cmt_rt   = {t1[RW-1:0], t0[RW-1:0]};
        cmt_id   = {t3[IDW-1:0], t2[IDW-1:0]};
        rel_v    = v.rel[0];
        rel_ckpt = v.relc[CW-1:0];
        miss_v   = v.miss[0];
        miss_ckpt = v.missc[CW-1:0];
    endtask

    initial begin
        vec_t v;
        vec_t idle;
        int   r;
        idle = '{0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,1,0};
        drive(idle);
        rst = 1'b1;

        //       rst dv dw rt0 id0 rt1 id1 br  cv crt0 cid0 crt1 cid1  rel rc miss mc  chk ep es ok aid
        add('{1, 0, 0, 0,  0,  0,  0,  0,  0, 0,  0,  0,  0,   0, 0, 0, 0,   5, 0, 0, 1, 0}); // 0 reset
        add('{0, 3, 3, 5,  3,  5,  6,  0,  0, 0,  0,  0,  0,   0, 0, 0, 0,   5, 1, 6, 1, 0}); // 1 slot1 wins
        add('{0, 0, 0, 0,  0,  0,  0,  0,  1, 5,  3,  0,  0,   0, 0, 0, 0,   5, 1, 6, 1, 0}); // 2 stale commit
        add('{0, 0, 0, 0,  0,  0,  0,  0,  2, 0,  0,  5,  6,   0, 0, 0, 0,   5, 0, 0, 1, 0}); // 3 commit port1
        add('{0, 3, 3, 7,  2,  8,  5,  1,  0, 0,  0,  0,  0,   0, 0, 0, 0,   7, 1, 2, 1, 1}); // 4 br slot0 -> ck0
        add('{0, 1, 1, 7,  4,  0,  0,  0,  0, 0,  0,  0,  0,   0, 0, 0, 0,   7, 1, 4, 1, 1}); // 5 younger r7
        add('{0, 1, 1, 7,  7,  0,  0,  0,  0, 0,  0,  0,  0,   0, 0, 1, 0,   7, 1, 2, 1, 0}); // 6 miss ck0, dec ignored
        add('{0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  0,  0,  0,   0, 0, 0, 0,   8, 0, 0, 1, 0}); // 7 slot1 excluded
        add('{0, 1, 1, 10, 1,  0,  0,  1,  0, 0,  0,  0,  0,   0, 0, 0, 0,  10, 1, 1, 1, 1}); // 8 ck0
        add('{0, 3, 3, 12, 3, 11,  2,  2,  0, 0,  0,  0,  0,   0, 0, 0, 0,  11, 1, 2, 1, 2}); // 9 ck1 on slot1
        add('{0, 1, 1, 13, 4,  0,  0,  1,  0, 0,  0,  0,  0,   0, 0, 0, 0,  13, 1, 4, 1, 3}); // 10 ck2
        add('{0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  0,  0,  0,   0, 0, 1, 1,  13, 0, 0, 1, 1}); // 11 miss ck1 frees 1,2
        add('{0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  0,  0,  0,   0, 0, 0, 0,  11, 1, 2, 1, 1}); // 12
        add('{0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  0,  0,  0,   0, 0, 0, 0,  12, 1, 3, 1, 1}); // 13 slot0 in snapshot
        add('{0, 1, 1, 9,  1,  0,  0,  1,  0, 0,  0,  0,  0,   0, 0, 0, 0,   9, 1, 1, 1, 2}); // 14 ck1 holds r9/id1
        add('{0, 1, 1, 9,  5,  0,  0,  0,  0, 0,  0,  0,  0,   0, 0, 0, 0,   9, 1, 5, 1, 2}); // 15
        add('{0, 0, 0, 0,  0,  0,  0,  0,  1, 9,  1,  0,  0,   0, 0, 1, 1,   9, 0, 0, 1, 1}); // 16 commit+miss
        add('{0, 1, 1, 20, 0,  0,  0,  1,  0, 0,  0,  0,  0,   0, 0, 0, 0,  20, 1, 0, 1, 2}); // 17 ck1
        add('{0, 1, 1, 21, 1,  0,  0,  1,  0, 0,  0,  0,  0,   0, 0, 0, 0,  21, 1, 1, 1, 3}); // 18 ck2
        add('{0, 1, 1, 22, 2,  0,  0,  1,  0, 0,  0,  0,  0,   0, 0, 0, 0,  22, 1, 2, 0, 0}); // 19 ck3 full
        add('{0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  0,  0,  0,   1, 2, 0, 0,  22, 1, 2, 1, 2}); // 20 rel ck2
        add('{0, 1, 1, 23, 3,  0,  0,  1,  0, 0,  0,  0,  0,   0, 0, 0, 0,  23, 1, 3, 0, 0}); // 21 realloc ck2
        add('{1, 1, 1, 24, 4,  0,  0,  1,  0, 0,  0,  0,  0,   0, 0, 0, 0,  24, 0, 0, 1, 0}); // 22 rst wins
        add('{0, 1, 1, 0,  7,  0,  0,  0,  0, 0,  0,  0,  0,   0, 0, 0, 0,   0, 0, 0, 1, 0}); // 23 r0 never pending
        add('{0, 1, 1, 5,  2,  0,  0,  0,  0, 0,  0,  0,  0,   0, 0, 0, 0,   5, 1, 2, 1, 0}); // 24
        add('{0, 1, 1, 5,  7,  0,  0,  0,  1, 5,  2,  0,  0,   0, 0, 0, 0,   5, 1, 7, 1, 0}); // 25 dec beats commit

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            drive(tv[i]);
            @(posedge clk);
            #1;
            r = tv[i].chk;
            $display("vec%0d r%0d pend=%0d src=%0d ckpt_ok=%0d alloc_id=%0d", i, r,
                     reg_pending[r], reg_src[r*IDW +: IDW], ckpt_ok, ckpt_alloc_id);
            check("pending", i, int'(reg_pending[r]), tv[i].ep);
            if (tv[i].ep != 0) check("src", i, int'(reg_src[r*IDW +: IDW]), tv[i].es);
            check("ckpt_ok", i, int'(ckpt_ok), tv[i].eok);
            if (tv[i].eok != 0) check("alloc_id", i, int'(ckpt_alloc_id), tv[i].eaid);
        end

        // Mid-sequence reset from a busy state: whole map and allocator must return to reset values
        @(negedge clk);
        v = '{1,1,1,30,6,0,0,1, 0,0,0,0,0, 0,0,0,0, 0,0,0,1,0};
        drive(v);
        @(posedge clk);
        #1;
        $display("rst: pending_ones=%0d src_nonzero=%0d ckpt_ok=%0d alloc_id=%0d",
                 $countones(reg_pending), int'(reg_src != '0), ckpt_ok, ckpt_alloc_id);
        check("rst_pending_all", tv.size(), $countones(reg_pending), 0);
        check("rst_src_all", tv.size(), int'(reg_src != '0), 0);
        check("rst_ckpt_ok", tv.size(), int'(ckpt_ok), 1);
        check("rst_alloc_id", tv.size(), int'(ckpt_alloc_id), 0);

        @(negedge clk);
        drive(idle);
        @(posedge clk);
        #1;
        $display("post-rst idle: r30 pend=%0d alloc_id=%0d", reg_pending[30], ckpt_alloc_id);
        check("post_rst_r30", tv.size() + 1, int'(reg_pending[30]), 0);
        check("post_rst_alloc", tv.size() + 1, int'(ckpt_alloc_id), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
